// File: rtl/sprite_animator_pkg.sv
// Shared sprite-sheet constants, action encodings and small helpers for the
// animated sprite pixel source.
package sprite_animator_pkg;

    localparam int          CHR_SPR_W     = 31;
    localparam int          CHR_SPR_H     = 23;
    localparam int          CHR_N_FRAMES  = 4;
    localparam int          CHR_N_ACTIONS = 4;
    localparam logic [11:0] CHR_KEY_RGB   = 12'hFFF;

    typedef enum logic [1:0] {
        ACT_IDLE = 2'd0,
        ACT_RUN  = 2'd1,
        ACT_JUMP = 2'd2,
        ACT_FALL = 2'd3
    } action_e;

    typedef enum logic {
        ANIM_PLAY = 1'b0,
        ANIM_HOLD = 1'b1
    } anim_state_e;

    function automatic logic is_opaque(input logic [11:0] rgb, input logic [11:0] key);
        return rgb != key;
    endfunction

endpackage

// File: rtl/sprite_anim_ctr.sv
// Per-video-frame action/facing latch plus the animation divider, frame
// counter and play-once hold state.
module sprite_anim_ctr
    import sprite_animator_pkg::*;
#(
    parameter int                   N_FRAMES  = CHR_N_FRAMES,
    parameter int                   N_ACTIONS = CHR_N_ACTIONS,
    parameter int                   ANIM_DIV  = 1,
    parameter logic [N_ACTIONS-1:0] LOOP_MASK = 4'b0011,
    parameter int                   ACT_W     = (N_ACTIONS > 1) ? $clog2(N_ACTIONS) : 1,
    parameter int                   FRM_W     = (N_FRAMES > 1) ? $clog2(N_FRAMES) : 1
)(
    input  logic             clk,
    input  logic             rst,
    input  logic             frame_tick,
    input  logic [ACT_W-1:0] action,
    input  logic             dir,
    output logic [ACT_W-1:0] act_q,
    output logic             dir_q,
    output logic [FRM_W-1:0] frame
);

    localparam int         DIV_W    = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;
    localparam [DIV_W-1:0] DIV_LAST = DIV_W'(ANIM_DIV - 1);
    localparam [FRM_W-1:0] FRM_LAST = FRM_W'(N_FRAMES - 1);

    anim_state_e      state_r, state_s;
    logic [ACT_W-1:0] act_r, act_s;
    logic             dir_r, dir_s;
    logic [FRM_W-1:0] frame_r, frame_s;
    logic [DIV_W-1:0] div_r, div_s;

    // Animation state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ANIM_PLAY;
            act_r   <= '0;
            dir_r   <= 1'b1;
            frame_r <= '0;
            div_r   <= '0;
        end else begin
            state_r <= state_s;
            act_r   <= act_s;
            dir_r   <= dir_s;
            frame_r <= frame_s;
            div_r   <= div_s;
        end
    end

    // Next state: an action change on the tick always restarts the animation,
    // so the divider and frame counter never advance on that tick.
    always_comb begin
        state_s = state_r;
        act_s   = act_r;
        dir_s   = dir_r;
        frame_s = frame_r;
        div_s   = div_r;
        if (frame_tick) begin
            act_s = action;
            dir_s = dir;
            if (action != act_r) begin
                state_s = ANIM_PLAY;
                frame_s = '0;
                div_s   = '0;
            end else if (div_r == DIV_LAST) begin
                div_s = '0;
                case (state_r)
                    ANIM_PLAY: begin
                        if (frame_r != FRM_LAST) begin
                            frame_s = frame_r + FRM_W'(1);
                        end else if (LOOP_MASK[act_r]) begin
                            frame_s = '0;
                        end else begin
                            state_s = ANIM_HOLD;
                        end
                    end
                    ANIM_HOLD: begin
                        frame_s = frame_r;
                    end
                    default: begin
                        state_s = ANIM_PLAY;
                        frame_s = '0;
                    end
                endcase
            end else begin
                div_s = div_r + DIV_W'(1);
            end
        end else begin
            div_s = div_r;
        end
    end

    assign act_q = act_r;
    assign dir_q = dir_r;
    assign frame = frame_r;

endmodule

// File: rtl/sprite_animator.sv
// Animated sprite pixel source: box test, packed-sheet addressing with
// mirroring, and a latency-aligned transparency-keyed pixel output.
module sprite_animator
    import sprite_animator_pkg::*;
#(
    parameter int                   SPR_W     = CHR_SPR_W,
    parameter int                   SPR_H     = CHR_SPR_H,
    parameter int                   N_FRAMES  = CHR_N_FRAMES,
    parameter int                   N_ACTIONS = CHR_N_ACTIONS,
    parameter int                   ANIM_DIV  = 1,
    parameter logic [N_ACTIONS-1:0] LOOP_MASK = 4'b0011,
    parameter int                   ROM_LAT   = 1,
    parameter logic [11:0]          KEY_RGB   = CHR_KEY_RGB,
    parameter int                   ADDR_W    = $clog2(N_ACTIONS*N_FRAMES*SPR_W*SPR_H),
    localparam int                  ACT_W     = (N_ACTIONS > 1) ? $clog2(N_ACTIONS) : 1
)(
    input  logic              clk,
    input  logic              rst,
    input  logic              frame_tick,
    input  logic [9:0]        col,
    input  logic [9:0]        row,
    input  logic [9:0]        pos_x,
    input  logic [9:0]        pos_y,
    input  logic [ACT_W-1:0]  action,
    input  logic              dir,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [11:0]       rom_rgb,
    output logic              pix_valid,
    output logic [11:0]       pix_rgb,
    output logic [9:0]        anchor_x,
    output logic [9:0]        anchor_y
);

    localparam int FRM_W = (N_FRAMES > 1) ? $clog2(N_FRAMES) : 1;

    logic [ACT_W-1:0]  act_q_s;
    logic              dir_q_s;
    logic [FRM_W-1:0]  frame_s;

    logic [10:0]       col_e_s, row_e_s, px_e_s, py_e_s;
    logic [10:0]       dx_s, dy_s;
    logic              in_box_s;
    logic [ADDR_W-1:0] ax_s, line_s, addr_s;
    logic              opaque_s;
    logic [ROM_LAT:0]  box_sr_r;

    sprite_anim_ctr #(
        .N_FRAMES  (N_FRAMES),
        .N_ACTIONS (N_ACTIONS),
        .ANIM_DIV  (ANIM_DIV),
        .LOOP_MASK (LOOP_MASK),
        .ACT_W     (ACT_W),
        .FRM_W     (FRM_W)
    ) u_ctr (
        .clk        (clk),
        .rst        (rst),
        .frame_tick (frame_tick),
        .action     (action),
        .dir        (dir),
        .act_q      (act_q_s),
        .dir_q      (dir_q_s),
        .frame      (frame_s)
    );

    // Box test and sheet address; 11-bit compares keep sprites near 1023 from wrapping.
    always_comb begin
        col_e_s  = {1'b0, col};
        row_e_s  = {1'b0, row};
        px_e_s   = {1'b0, pos_x};
        py_e_s   = {1'b0, pos_y};
        in_box_s = (col_e_s >= px_e_s) && (col_e_s < px_e_s + 11'(SPR_W)) &&
                   (row_e_s >= py_e_s) && (row_e_s < py_e_s + 11'(SPR_H));
        dx_s     = col_e_s - px_e_s;
        dy_s     = row_e_s - py_e_s;
        if (dir_q_s) begin
            ax_s = ADDR_W'(dx_s);
        end else begin
            ax_s = ADDR_W'(SPR_W - 1) - ADDR_W'(dx_s);
        end
        line_s = (ADDR_W'(act_q_s) * ADDR_W'(N_FRAMES) + ADDR_W'(frame_s)) * ADDR_W'(SPR_H)
                 + ADDR_W'(dy_s);
        if (in_box_s) begin
            addr_s = line_s * ADDR_W'(SPR_W) + ax_s;
        end else begin
            addr_s = '0;
        end
        opaque_s = box_sr_r[ROM_LAT] && is_opaque(rom_rgb, KEY_RGB);
    end

    // Address, box delay line (aligned with ROM data), pixel output and anchor registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rom_addr  <= '0;
            box_sr_r  <= '0;
            pix_valid <= 1'b0;
            pix_rgb   <= 12'h000;
            anchor_x  <= 10'd0;
            anchor_y  <= 10'd0;
        end else begin
            rom_addr  <= addr_s;
            box_sr_r  <= {box_sr_r[ROM_LAT-1:0], in_box_s};
            pix_valid <= opaque_s;
            pix_rgb   <= opaque_s ? rom_rgb : 12'h000;
            anchor_x  <= pos_x + 10'(SPR_W / 2);
            anchor_y  <= pos_y + 10'(SPR_H / 2);
        end
    end

endmodule

// File: tb/tb_sprite_animator.sv
// Self-checking bench for sprite_animator: directed vector table, hand-written
// animation/transparency sequences and randomized scan against a reference model.
module tb_sprite_animator;
    import sprite_animator_pkg::*;

    localparam int          SPR_W    = 31;
    localparam int          SPR_H    = 23;
    localparam int          NF       = 4;
    localparam int          NA       = 4;
    localparam int          ANIM_DIV = 2;
    localparam int          ROM_LAT  = 1;
    localparam logic [11:0] KEY      = 12'hFFF;
    localparam int          ADDR_W   = $clog2(NA*NF*SPR_W*SPR_H);
    localparam int          PIPE     = 1 + ROM_LAT;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              frame_tick;
    logic [9:0]        col, row, pos_x, pos_y;
    logic [1:0]        action;
    logic              dir;
    logic [ADDR_W-1:0] rom_addr;
    logic [11:0]       rom_rgb;
    logic              pix_valid;
    logic [11:0]       pix_rgb;
    logic [9:0]        anchor_x, anchor_y;

    int checks = 0;
    int errors = 0;

    logic        rom_force = 1'b0;
    logic [11:0] rom_force_val = 12'h000;
    logic [11:0] rom_pipe [ROM_LAT];
    logic [3:0]  loop_mask_v = 4'b0011;

    int m_act, m_dir, m_frame, m_div;

    typedef struct { logic v; logic [11:0] rgb; } pix_t;
    pix_t pq[$];

    typedef struct { int px; int py; int cx; int cy; bit d; int exp; } vec_t;
    vec_t tbl[16];
    int   jump_f[10];
    int   run_f[10];

    always #5 clk = ~clk;

    sprite_animator #(
        .SPR_W(SPR_W), .SPR_H(SPR_H), .N_FRAMES(NF), .N_ACTIONS(NA),
        .ANIM_DIV(ANIM_DIV), .LOOP_MASK(4'b0011), .ROM_LAT(ROM_LAT), .KEY_RGB(KEY)
    ) dut (
        .clk(clk), .rst(rst), .frame_tick(frame_tick),
        .col(col), .row(row), .pos_x(pos_x), .pos_y(pos_y),
        .action(action), .dir(dir),
        .rom_addr(rom_addr), .rom_rgb(rom_rgb),
        .pix_valid(pix_valid), .pix_rgb(pix_rgb),
        .anchor_x(anchor_x), .anchor_y(anchor_y)
    );

    function automatic logic [11:0] rom_func(input int a);
        logic [31:0] h;
        h = a * 37 + 5;
        if (a % 8 == 0) return KEY;
        return h[11:0];
    endfunction

    always @(posedge clk) begin
        rom_pipe[0] <= rom_func(int'(rom_addr));
        for (int i = 1; i < ROM_LAT; i++) rom_pipe[i] <= rom_pipe[i-1];
    end
    assign rom_rgb = rom_force ? rom_force_val : rom_pipe[ROM_LAT-1];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: sprite covers pixel, sheet address from the latched state.
    function automatic void model_pixel(output bit box, output int addr);
        int cx, cy, px, py, dx, dy, ax;
        cx = col; cy = row; px = pos_x; py = pos_y;
        box = (cx >= px) && (cx < px + SPR_W) && (cy >= py) && (cy < py + SPR_H);
        dx = cx - px; dy = cy - py;
        ax = (m_dir != 0) ? dx : SPR_W - 1 - dx;
        addr = box ? ((m_act * NF + m_frame) * SPR_H + dy) * SPR_W + ax : 0;
    endfunction

    task automatic model_tick();
        if (int'(action) != m_act) begin
            m_frame = 0;
            m_div = 0;
        end else if (m_div == ANIM_DIV - 1) begin
            m_div = 0;
            if (loop_mask_v[m_act]) m_frame = (m_frame + 1) % NF;
            else if (m_frame + 1 < NF) m_frame = m_frame + 1;
        end else begin
            m_div = m_div + 1;
        end
        m_act = int'(action);
        m_dir = int'(dir);
    endtask

    // One clock with current inputs; checks address, anchor and aligned pixel.
    task automatic step();
        bit          box;
        int          addr, ax_exp, ay_exp;
        pix_t        e;
        logic [11:0] r;
        model_pixel(box, addr);
        e.v = 1'b0;
        e.rgb = 12'h000;
        r = rom_force ? rom_force_val : rom_func(addr);
        if (box && r != KEY) begin
            e.v = 1'b1;
            e.rgb = r;
        end
        pq.push_back(e);
        ax_exp = (int'(pos_x) + SPR_W / 2) % 1024;
        ay_exp = (int'(pos_y) + SPR_H / 2) % 1024;
        if (frame_tick) model_tick();
        @(posedge clk);
        #1;
        check("rom_addr", int'(rom_addr), addr);
        check("anchor_x", int'(anchor_x), ax_exp);
        check("anchor_y", int'(anchor_y), ay_exp);
        if (pq.size() == PIPE + 1) begin
            e = pq.pop_front();
            check("pix_valid", int'(pix_valid), int'(e.v));
            check("pix_rgb", int'(pix_rgb), int'(e.rgb));
        end
    endtask

    task automatic tick_step();
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        step();
    endtask

    task automatic flush();
        pos_x = 10'd500; pos_y = 10'd500; col = 10'd0; row = 10'd0;
        for (int i = 0; i < PIPE + 2; i++) step();
    endtask

    task automatic do_reset(input int hold_cycles);
        frame_tick = 1'b0;
        rst = 1'b0;
        #1;
        check("rst_addr", int'(rom_addr), 0);
        check("rst_valid", int'(pix_valid), 0);
        check("rst_rgb", int'(pix_rgb), 0);
        check("rst_anchor_x", int'(anchor_x), 0);
        check("rst_anchor_y", int'(anchor_y), 0);
        for (int i = 0; i < hold_cycles; i++) begin
            @(posedge clk);
            #1;
            check("rst_hold_addr", int'(rom_addr), 0);
            check("rst_hold_valid", int'(pix_valid), 0);
            check("rst_hold_rgb", int'(pix_rgb), 0);
        end
        rst = 1'b1;
        m_act = 0; m_dir = 1; m_frame = 0; m_div = 0;
        pq.delete();
        for (int i = 0; i < PIPE; i++) pq.push_back('{1'b0, 12'h000});
    endtask

    initial begin
        tbl[0]  = '{100,   50,  103,   55, 1'b1, 4436};
        tbl[1]  = '{100,   50,  100,   50, 1'b1, 4278};
        tbl[2]  = '{100,   50,  130,   72, 1'b1, 4990};
        tbl[3]  = '{100,   50,  131,   55, 1'b1, 0};
        tbl[4]  = '{100,   50,   99,   55, 1'b1, 0};
        tbl[5]  = '{100,   50,  103,   73, 1'b1, 0};
        tbl[6]  = '{1010,  50,    5,   55, 1'b1, 0};
        tbl[7]  = '{1010,  50, 1020,   55, 1'b1, 4443};
        tbl[8]  = '{100, 1010,  103,    3, 1'b1, 0};
        tbl[9]  = '{1000, 1010, 1023, 1023, 1'b1, 4704};
        tbl[10] = '{100,   50,  103,   55, 1'b0, 4460};
        tbl[11] = '{100,   50,  100,   50, 1'b0, 4308};
        tbl[12] = '{100,   50,  130,   72, 1'b0, 4960};
        tbl[13] = '{1010,  50, 1020,   55, 1'b0, 4453};
        tbl[14] = '{1010,  50,    5,   55, 1'b0, 0};
        tbl[15] = '{1000, 1010, 1023, 1023, 1'b0, 4688};
        jump_f = '{0, 0, 1, 1, 2, 2, 3, 3, 3, 3};
        run_f  = '{0, 0, 1, 1, 2, 2, 3, 3, 0, 0};

        frame_tick = 1'b0;
        pos_x = 10'd100; pos_y = 10'd50; col = 10'd103; row = 10'd55;
        action = ACT_RUN; dir = 1'b1;
        #2;
        do_reset(3);

        // Reach RUN frame 2 (first tick is an action change from IDLE).
        for (int i = 0; i < 5; i++) tick_step();

        for (int i = 0; i < 16; i++) begin
            if (tbl[i].d != dir) begin
                dir = tbl[i].d;
                tick_step();
            end
            pos_x = 10'(tbl[i].px); pos_y = 10'(tbl[i].py);
            col = 10'(tbl[i].cx); row = 10'(tbl[i].cy);
            step();
            check($sformatf("tbl_addr[%0d]", i), int'(rom_addr), tbl[i].exp);
        end

        // Play-once JUMP holds its last frame; looping RUN wraps.
        pos_x = 10'd100; pos_y = 10'd50; col = 10'd100; row = 10'd50; dir = 1'b1;
        action = ACT_JUMP;
        for (int i = 0; i < 10; i++) begin
            tick_step();
            check($sformatf("anim_jump[%0d]", i), int'(rom_addr), (2 * NF + jump_f[i]) * SPR_H * SPR_W);
        end
        action = ACT_RUN;
        for (int i = 0; i < 10; i++) begin
            tick_step();
            check($sformatf("anim_run[%0d]", i), int'(rom_addr), (1 * NF + run_f[i]) * SPR_H * SPR_W);
        end

        // Action change between ticks must not show until the next tick.
        action = ACT_FALL;
        step();
        step();
        check("act_latched", int'(rom_addr), 4 * SPR_H * SPR_W);
        tick_step();
        check("act_change", int'(rom_addr), 12 * SPR_H * SPR_W);
        tick_step();
        check("fall_div", int'(rom_addr), 12 * SPR_H * SPR_W);
        tick_step();
        check("fall_step", int'(rom_addr), 13 * SPR_H * SPR_W);

        // Transparency keying and output latency.
        flush();
        rom_force = 1'b1; rom_force_val = 12'hFFF;
        pos_x = 10'd500; pos_y = 10'd500; col = 10'd505; row = 10'd505;
        for (int i = 0; i < PIPE + 2; i++) step();
        check("key_valid", int'(pix_valid), 0);
        check("key_rgb", int'(pix_rgb), 0);
        flush();
        rom_force_val = 12'h0F0;
        col = 10'd505; row = 10'd505;
        step();
        for (int i = 0; i < ROM_LAT; i++) step();
        check("opaque_early", int'(pix_valid), 0);
        step();
        check("opaque_valid", int'(pix_valid), 1);
        check("opaque_rgb", int'(pix_rgb), 12'h0F0);
        flush();
        rom_force = 1'b0;

        for (int n = 0; n < 2; n++) begin
            for (int i = 0; i < 500; i++) begin
                if ($urandom_range(0, 15) == 0) action = 2'($urandom_range(0, 3));
                if ($urandom_range(0, 7) == 0) dir = ~dir;
                frame_tick = ($urandom_range(0, 5) == 0);
                if ($urandom_range(0, 31) == 0) begin
                    pos_x = ($urandom_range(0, 1) == 1) ? 10'($urandom_range(990, 1023)) : 10'($urandom_range(0, 1023));
                    pos_y = ($urandom_range(0, 1) == 1) ? 10'($urandom_range(990, 1023)) : 10'($urandom_range(0, 1023));
                end
                col = 10'(int'(pos_x) + int'($urandom_range(0, 40)) - 5);
                row = 10'(int'(pos_y) + int'($urandom_range(0, 30)) - 4);
                step();
            end
            frame_tick = 1'b0;
            if (n == 0) begin
                pos_x = 10'd100; pos_y = 10'd50; col = 10'd103; row = 10'd55;
                do_reset(2);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sprite_animator.md
# sprite_animator

Parametrised animated-sprite pixel source for the VGA pipeline; the generalised successor of the per-character sprite block. Given the scan position, sprite position, action and facing, it produces a ROM address into a single packed sprite sheet, advances the animation frame on its own timebase, and returns a latency-aligned, transparency-keyed pixel with a valid flag to the layer compositor. Action and facing are latched once per video frame so a sprite never tears mid-scan.

## Interface
- SPR_W, 31: sprite width in pixels
- SPR_H, 23: sprite height in pixels
- N_FRAMES, 4: animation frames per action
- N_ACTIONS, 4: actions in the sheet
- ANIM_DIV, 1: frame_tick pulses per animation step (≥1)
- LOOP_MASK, 4'b0011: bit a=1 loops action a; bit a=0 plays once and holds last frame
- ROM_LAT, 1: external ROM read latency in cycles (≥1)
- KEY_RGB, 12'hFFF: transparent colour
- ADDR_W, $clog2(N_ACTIONS*N_FRAMES*SPR_W*SPR_H): ROM address width
- clk  in  1  pixel/system clock; all state on rising edge
- rst  in  1  asynchronous, active-low reset
- frame_tick  in  1  one-cycle pulse at start of vertical blank
- col, row  in  10 each  current scan position
- pos_x, pos_y  in  10 each  sprite top-left corner
- action  in  $clog2(N_ACTIONS)  requested action
- dir  in  1  1 = facing right (unmirrored), 0 = mirrored
- rom_addr  out  ADDR_W  registered sprite-sheet address
- rom_rgb  in  12  ROM data, valid ROM_LAT cycles after rom_addr
- pix_valid  out  1  sprite covers this pixel and it is opaque
- pix_rgb  out  12  sprite colour (0 when pix_valid=0)
- anchor_x, anchor_y  out  10 each  registered centre: pos + (SPR_W/2, SPR_H/2)

## Operation
- Reset (rst=0): rom_addr=0, pix_valid=0, pix_rgb=0, anchor=0, latched action=0, latched dir=1, frame=0, div counter=0, hold flag=0, delay line cleared.
- Frame latch: on frame_tick, act_q<=action, dir_q<=dir. anchor updates from pos every cycle.
- Animation FSM per frame_tick: if action≠act_q (change) → frame=0, div=0, hold=0. Else div increments; at div=ANIM_DIV-1 → div=0 and step: looping action wraps frame N_FRAMES-1→0; non-looping action at N_FRAMES-1 sets hold and stays.
- Box test in 11-bit unsigned arithmetic: in_box = col≥pos_x && col<pos_x+SPR_W && row≥pos_y && row<pos_y+SPR_H; sprites near the 1023 boundary must not wrap.
- dx=col-pos_x, dy=row-pos_y; ax = dir_q ? dx : SPR_W-1-dx.
- rom_addr <= in_box ? ((act_q*N_FRAMES+frame)*SPR_H + dy)*SPR_W + ax : 0.
- in_box shifts through a ROM_LAT-deep delay line alongside the read.
- Output stage: opaque = box_d && rom_rgb≠KEY_RGB; pix_valid<=opaque; pix_rgb<=opaque ? rom_rgb : 0.
- Simultaneous frame_tick and action change: change wins; the frame counter never steps that tick.
- Async reset mid-frame clears everything immediately; first valid pixel again requires ROM_LAT+2 cycles of in-box scan.

## Timing
- col/row at cycle t → rom_addr at t+1 → rom_rgb at t+1+ROM_LAT → pix_valid/pix_rgb at t+2+ROM_LAT. Compositor must delay other layers identically.
- Action/dir/frame changes become visible on addresses issued the cycle after frame_tick.
- Animation period: ANIM_DIV video frames per step.

## Structure
- Shared package: sprite sheet constants per character (SPR_W, SPR_H, N_FRAMES), action encodings (IDLE=0, RUN=1, JUMP=2, FALL=3), KEY_RGB.
- One sub-module: sprite_anim_ctr (action latch, divider, frame counter, hold logic).
- Sprite ROMs stay external; one packed sheet replaces per-action ROMs.

## Test plan
- Reset: hold rst=0 with in-box scan → rom_addr=0, pix_valid=0, pix_rgb=0; release → first pix_valid no earlier than ROM_LAT+2 cycles.
- Address: pos=(100,50), act=1, frame=2, dir=1, scan (103,55) → rom_addr=((1*4+2)*23+5)*31+3=4436; dir=0 → ax=27, rom_addr=4460.
- Animation: ANIM_DIV=2, action=RUN constant, 8 frame_ticks → frame 0,0,1,1,2,2,3,3 then 0; action JUMP (non-looping) holds at 3.
- Action change mid-frame: change action between ticks → addresses unchanged until next frame_tick, then frame=0.
- Transparency: rom_rgb=12'hFFF in box → pix_valid=0; rom_rgb=12'h0F0 → pix_valid=1, pix_rgb=12'h0F0 at t+2+ROM_LAT.
- Edge: pos_x=1010, col=5 → in_box=0 (no wrap); col=1020 → in_box=1, dx=10.
